lr35902_oam_dma: RTL
====================

LR35902_OAM_DMA -- requirements
Module: lr35902_oam_dma

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port ce, input, 1, M-cycle strobe; all CPU accesses and DMA steps take effect only on a clk edge with ce=1.
REQ-004 SHALL have CPU-side ports: cpu_adr in 16; cpu_rd in 1; cpu_wr in 1; cpu_dout in 8 (write data); cpu_din out 8 (read data).
REQ-005 SHALL have main-bus ports for 0x0000-0xFEFF: bus_adr out 16; bus_rd out 1; bus_wr out 1; bus_dout out 8; bus_din in 8.
REQ-006 SHALL have I/O-side ports for 0xFF00-0xFFFF: io_adr out 8; io_rd out 1; io_wr out 1; io_dout out 8; io_din in 8.
REQ-007 SHALL have dedicated OAM write-port ports: oam_adr out 8; oam_we out 1; oam_wdata out 8.
REQ-008 SHALL have port dma_active, out, 1, high in START and XFER.

Function
REQ-009 SHALL implement FSM states IDLE, START, XFER; state register, src_hi[7:0] and idx[7:0] are registered.
REQ-010 SHALL treat a CPU write to 0xFF46 (cpu_wr & ce) as a DMA trigger: latch cpu_dout into src_hi and enter START from any state.
REQ-011 SHALL return src_hi on cpu_din for a CPU read of 0xFF46, without asserting io_rd.
REQ-012 SHALL move START -> XFER with idx=0 on the next ce after the trigger.
REQ-013 SHALL, in XFER, drive bus_adr={eff_hi,idx}, bus_rd=1, bus_wr=0, oam_adr=idx, oam_wdata=bus_din, and oam_we=ce (combinational).
REQ-014 SHALL set eff_hi = src_hi - 0x20 when src_hi >= 0xE0, else src_hi (FE/FF sources read the WRAM mirror).
REQ-015 SHALL increment idx on each ce in XFER; on the ce with idx=159 SHALL return to IDLE (160 bytes; dma_active high for 161 M-cycles).
REQ-016 SHALL, in IDLE and START, pass CPU accesses to 0x0000-0xFEFF through to bus_* unchanged, with cpu_din=bus_din.
REQ-017 SHALL, in XFER, drop CPU writes to 0x0000-0xFEFF and return cpu_din=0xFF for CPU reads of that range.
REQ-018 SHALL always route CPU accesses to 0xFF00-0xFFFF except 0xFF46 to io_* (io_adr=cpu_adr[7:0], cpu_din=io_din), regardless of DMA state.
REQ-019 SHALL route a CPU write to 0xFF46 to both src_hi and io_wr, so other I/O logic stays consistent.
REQ-020 SHALL, for a trigger arriving in XFER, still write the current byte on that ce, then restart at START with the new src_hi and idx cleared.
REQ-021 SHALL keep oam_we=0 outside XFER and bus_rd, bus_wr, io_rd and io_wr deasserted when there is no corresponding access.

Reset
REQ-022 SHALL, on reset=1 at a clk edge, set state=IDLE, idx=0x00 and src_hi=0x00, overriding a simultaneous trigger.
REQ-023 SHALL, while reset=1, hold dma_active=0 and oam_we=0 and deassert all bus_*/io_* strobes; an aborted transfer is not resumed.

Structure
REQ-024 SHALL take DMA_REG_ADR=16'hFF46, DMA_LEN=160 and the FSM state encoding from shared package lr35902_pkg.
REQ-025 SHALL be implemented flat as one FSM plus a counter; no sub-module is warranted.

Verification
REQ-026 SHALL verify: write 0xC1 to FF46 -> one START M-cycle, then 160 oam_we pulses at bus_adr C100..C19F to oam_adr 00..9F, then dma_active drops.
REQ-027 SHALL verify: write 0xFE to FF46 -> bus_adr sequence DE00..DE9F.
REQ-028 SHALL verify: during XFER, CPU read 0x8000 -> 0xFF, CPU write 0xC000 -> no bus_wr, CPU read FF80 -> io_rd=1 and data passed through.
REQ-029 SHALL verify: after 50 bytes, write 0x80 to FF46 -> byte 49 written, START, then restart at 8000 with idx=0 and 160 new bytes.
REQ-030 SHALL verify: reset asserted at idx=100 -> IDLE next edge, no further oam_we, FF46 reads 0x00.
REQ-031 SHALL verify: ce held low for 10 clks mid-XFER -> idx and state frozen, no oam_we.

Source files
------------

// File: rtl/lr35902_pkg.sv
// Shared constants and types for the LR35902 OAM DMA engine.
// Holds the DMA register address, transfer length and FSM state encoding.
package lr35902_pkg;

    localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
    localparam int          DMA_LEN     = 160;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_t;

    // Sources in E0..FF would hit echo/OAM/IO space; fold them onto WRAM.
    function automatic logic [7:0] dma_eff_hi(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/lr35902_oam_dma.sv
// LR35902 OAM DMA: copies 160 bytes from {src_hi,00} to OAM, one byte per ce strobe.
// CPU bus accesses pass through; main-bus CPU traffic is locked out while bytes are copied.
module lr35902_oam_dma
    import lr35902_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,

    input  logic [15:0] cpu_adr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,

    output logic [15:0] bus_adr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,

    output logic [7:0]  io_adr,
    output logic        io_rd,
    output logic        io_wr,
    output logic [7:0]  io_dout,
    input  logic [7:0]  io_din,

    output logic [7:0]  oam_adr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,

    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t state, state_nxt;
    logic [7:0] src_hi, src_hi_nxt;
    logic [7:0] idx, idx_nxt;

    logic is_dma_reg;
    logic is_io;
    logic xfer;
    logic trigger;

    assign is_dma_reg = (cpu_adr == DMA_REG_ADR);
    assign is_io      = (cpu_adr[15:8] == 8'hFF);
    assign xfer       = (state == ST_XFER);
    assign trigger    = ce && cpu_wr && is_dma_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            src_hi <= 8'h00;
            idx    <= 8'h00;
        end else begin
            state  <= state_nxt;
            src_hi <= src_hi_nxt;
            idx    <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        src_hi_nxt = src_hi;
        idx_nxt    = idx;
        if (ce) begin
            case (state)
                ST_START: begin
                    state_nxt = ST_XFER;
                    idx_nxt   = 8'h00;
                end
                ST_XFER: begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = 8'h00;
                    end else begin
                        idx_nxt = idx + 8'h01;
                    end
                end
                default: ;
            endcase
            // A retrigger mid-transfer still lets the current byte land (oam_we is combinational).
            if (trigger) begin
                src_hi_nxt = cpu_dout;
                state_nxt  = ST_START;
                idx_nxt    = 8'h00;
            end
        end
    end

    always_comb begin
        bus_adr    = cpu_adr;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        bus_dout   = cpu_dout;
        io_adr     = cpu_adr[7:0];
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        io_dout    = cpu_dout;
        oam_adr    = idx;
        oam_we     = 1'b0;
        oam_wdata  = bus_din;
        cpu_din    = 8'hFF;
        dma_active = 1'b0;
        if (!reset) begin
            dma_active = (state != ST_IDLE);
            if (xfer) begin
                bus_adr = {dma_eff_hi(src_hi), idx};
                bus_rd  = 1'b1;
                oam_we  = ce;
            end
            // FF46 writes also reach io_wr so any shadow copy elsewhere stays in step.
            if (is_dma_reg) begin
                cpu_din = src_hi;
                io_wr   = cpu_wr;
            end else if (is_io) begin
                io_rd   = cpu_rd;
                io_wr   = cpu_wr;
                cpu_din = io_din;
            end else if (!xfer) begin
                bus_rd  = cpu_rd;
                bus_wr  = cpu_wr;
                cpu_din = bus_din;
            end
        end
    end

endmodule
